// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches words over req/ack, presents
// the instruction to decode and commits the next PC, halting on a misaligned target.
//
// state | meaning
// BOOT  | one idle cycle after reset release
// FETCH | request outstanding at pc, waiting for ack
// HOLD  | instruction valid, waiting for an unstalled commit
// HALT  | misaligned next-PC seen; sticky until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] immext_i,
  input  logic [31:0] jalr_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] pc_d;

  // pcsrc 11 is treated as sequential flow
  always_comb begin
    pc_d = pc_q + 32'd4;
    case (pcsrc_i)
      2'b01:   pc_d = pc_q + immext_i;
      2'b10:   pc_d = {jalr_target_i[31:1], 1'b0};
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (pc_d[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pcplus4_o     = pc_q + 32'd4;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// HOLD contents; a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SEED = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pcsrc = 2'b00;
  logic [31:0] immext = 32'd0;
  logic [31:0] jalr_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fault;

  int          vectors = 0;
  int          miscompares = 0;

  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;
  int          wait_n = 0;
  int          wait_ctr = 0;
  logic        valid_prev = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .pcsrc_i(pcsrc), .immext_i(immext),
    .jalr_target_i(jalr_target), .stall_i(stall), .imem_req_o(imem_req),
    .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc),
    .pcplus4_o(pcplus4), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // Memory model: word contents derived from the address, ack after wait_n cycles
  assign imem_rdata = imem_addr ^ SEED;
  assign imem_ack   = ack_force | (imem_req & ack_en & (wait_ctr >= wait_n));

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_ctr <= wait_ctr + 1;
    else                       wait_ctr <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted fetches and the first cycle of each HOLD
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
        else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && !valid_prev) begin
        if (exp_pc_q.size() == 0) check("unexpected_hold", pc, 32'hxxxx_xxxx);
        else begin
          logic [31:0] ep;
          ep = exp_pc_q.pop_front();
          check("hold_pc", pc, ep);
          check("hold_instr", instr, ep ^ SEED);
          check("hold_pcplus4", pcplus4, ep + 32'd4);
        end
      end
    end
    valid_prev <= instr_valid;
  end

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", {31'd0, instr_valid}, 32'd1);
  endtask

  // Called in HOLD with stall high: drive feedback, keep stalled n cycles, then commit
  task automatic commit(input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] jt, input int nstall, input logic [31:0] cur_pc);
    pcsrc = src; immext = imm; jalr_target = jt;
    for (int i = 0; i < nstall; i++) begin
      @(negedge clk);
      check("stall_pc", pc, cur_pc);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1; pcsrc = 2'b00;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc",    pc,                   32'h0);
    check("rst_instr", instr,                NOP);
    check("rst_fault", {31'd0, fault},       32'd0);

    // zero-wait sequential flow
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    rst = 1'b0;
    #1 check("boot_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("seq_valid", {31'd0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    stall = 1'b1;

    // three ack wait-cycles at 0x10
    wait_n = 3;
    expect_fetch(32'h10);
    commit(2'b01, 32'h8, 32'h0, 0, 32'h8);
    for (int i = 0; i < 4; i++) begin
      check("wait_req",   {31'd0, imem_req},    32'd1);
      check("wait_addr",  imem_addr,            32'h10);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("wait_hold", {31'd0, instr_valid}, 32'd1);
    wait_n = 0;

    expect_fetch(32'h20);
    commit(2'b01, 32'h10, 32'h0, 0, 32'h10);
    wait_hold();
    // backward branch under a 2-cycle stall
    expect_fetch(32'h10);
    commit(2'b01, 32'hFFFF_FFF0, 32'h0, 2, 32'h20);
    wait_hold();
    expect_fetch(32'h40);
    commit(2'b01, 32'h30, 32'h0, 0, 32'h10);
    wait_hold();
    expect_fetch(32'h100);
    commit(2'b10, 32'h0, 32'h101, 0, 32'h40);
    wait_hold();
    check("jalr_fault", {31'd0, fault}, 32'd0);
    expect_fetch(32'hFFFF_FFFC);
    commit(2'b01, 32'hFFFF_FEFC, 32'h0, 0, 32'h100);
    wait_hold();
    expect_fetch(32'h0);
    commit(2'b11, 32'h1234_5678, 32'h0, 0, 32'hFFFF_FFFC);
    wait_hold();

    // misaligned target halts with pc unchanged
    commit(2'b01, 32'h2, 32'h0, 0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      check("halt_fault", {31'd0, fault},       32'd1);
      check("halt_pc",    pc,                   32'h0);
      check("halt_req",   {31'd0, imem_req},    32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_instr", instr,                NOP);
      @(negedge clk);
    end

    // reset out of HALT, then reset mid-FETCH with a late ack
    rst = 1'b1;
    @(negedge clk);
    check("rst2_fault", {31'd0, fault}, 32'd0);
    expect_fetch(32'h0);
    rst = 1'b0;
    wait_hold();
    ack_en = 1'b0;
    commit(2'b01, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("midf_req",  {31'd0, imem_req}, 32'd1);
    check("midf_addr", imem_addr,         32'h40);
    #1 rst = 1'b1;
    ack_en = 1'b1;
    #1;
    check("midf_rst_req", {31'd0, imem_req}, 32'd0);
    check("midf_rst_pc",  pc,                32'h0);
    @(negedge clk);
    expect_fetch(32'h0);
    rst = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("late_ack_req",  {31'd0, imem_req},    32'd1);
    check("late_ack_addr", imem_addr,            32'h0);
    check("late_ack_inst", instr,                NOP);
    wait_hold();
    repeat (2) @(negedge clk);

    check("addr_q_empty", exp_addr_q.size(), 32'd0);
    check("hold_q_empty", exp_pc_q.size(),   32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the single-cycle decode/control logic.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents a captured instruction with PC and PC+4 to decode/datapath, then commits next-PC from the pcsrc/immext/jalr-target feedback.
- Adds a halt-on-misaligned-target fault state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented while no valid fetch (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pcsrc  in  2  next-PC select from control: 00 PC+4, 01 PC+immext, 10 jalr target, 11 treated as PC+4.
- immext  in  32  sign-extended branch/jal offset.
- jalr_target  in  32  rs1+imm from ALU; bit0 is cleared before use.
- stall  in  1  downstream hold; blocks commit while high.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  32  word address of request; equals pc.
- imem_ack  in  1  memory has rdata valid this cycle; may assert in the same cycle as req.
- imem_rdata  in  32  fetched instruction, sampled only when imem_req&&imem_ack.
- instr  out  32  current instruction to decode.
- instr_valid  out  1  instr/pc/pcplus4 are valid.
- pc  out  32  address of instr.
- pcplus4  out  32  pc+32'd4, wraps modulo 2^32.
- fault  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, immediate): state=BOOT, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, fault=0.
- pcplus4 is combinational from pc.
- BOOT: one cycle after reset release with imem_req=0, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: instr<=imem_rdata, go to HOLD.
  - Without ack: remain in FETCH with pc and req stable.
- HOLD:
  - imem_req=0, instr_valid=1; instr and pc stable; decode computes pcsrc/immext/jalr_target combinationally.
  - Commit when instr_valid && !stall. Next PC on commit:
    - pcsrc 00/11: pc+4.
    - pcsrc 01: pc+immext.
    - pcsrc 10: {jalr_target[31:1],1'b0}.
  - All additions are 32-bit, overflow discarded.
  - If next[1:0]!=2'b00: pc is not updated, fault<=1, go to HALT.
  - Otherwise pc<=next, instr<=NOP_INSTR, go to FETCH.
  - stall high in HOLD: no change.
- HALT:
  - instr_valid=0, imem_req=0, instr=NOP_INSTR; pc holds the faulting instruction address.
  - Exit only via rst.
- Throughput: zero-wait memory gives 2 cycles per instruction (FETCH, HOLD); each ack wait-cycle adds 1.
- Simultaneous events:
  - stall is ignored outside HOLD.
  - imem_ack while imem_req=0 is ignored.
  - rst during FETCH drops imem_req the same instant; a late ack after reset release is ignored because the state is BOOT.
- Timing of instr_valid:
  - Never high in the cycle the captured data is sampled.
  - Rises the cycle after ack and falls the cycle after commit.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093, stall=0, pcsrc=00 -> BOOT 1 cycle; imem_addr 0,4,8 on successive FETCH cycles; instr_valid high every other cycle; pcplus4=pc+4.
- imem_ack delayed 3 cycles at pc=0x10 -> imem_req and imem_addr=0x10 held for 4 cycles; instr_valid=0 throughout; HOLD entered the cycle after ack.
- HOLD at pc=0x20, pcsrc=01, immext=32'hFFFF_FFF0, stall high 2 cycles then low -> pc stays 0x20 during stall; next fetch at 0x10.
- HOLD at pc=0x40, pcsrc=10, jalr_target=0x101 -> next fetch address 0x100 (bit0 cleared), no fault.
- HOLD, pcsrc=01, immext=0x2 -> fault=1; state HALT with pc unchanged; imem_req=0, instr_valid=0 for 10+ cycles; cleared only by rst.
- Wrap-around and reset:
  - pc=0xFFFF_FFFC, pcsrc=00 -> next fetch at 0x0.
  - Assert rst mid-FETCH with ack arriving 1 cycle after release -> outputs reset immediately; ack ignored; first fetch at RESET_PC after BOOT.
